// File: rtl/sub_share_if.sv
// ---------------------------------------------------------------------------
// sub_share_if -- request/response bundle for sub_share_arbiter.
//
// Request side (one lane per requester, flattened):
//   req_valid[i]                         requester i has an operand pair
//   req_minuend[i*WIDTH +: WIDTH]        minuend of requester i
//   req_subtrahend[i*WIDTH +: WIDTH]     subtrahend of requester i
//   req_ready[i]                         one-hot accept strobe for requester i
// Response side:
//   rsp_valid / rsp_ready                result handshake
//   rsp_diff, rsp_borrow, rsp_id         result payload and owning requester
//
// Modports: master = client/consumer side, slave = arbiter.
// ---------------------------------------------------------------------------
interface sub_share_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_minuend;
    logic [NREQ*WIDTH-1:0] req_subtrahend;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_diff;
    logic                  rsp_borrow;
    logic [IDW-1:0]        rsp_id;

    modport master (
        output req_valid, req_minuend, req_subtrahend, rsp_ready,
        input  req_ready, rsp_valid, rsp_diff, rsp_borrow, rsp_id
    );

    modport slave (
        input  req_valid, req_minuend, req_subtrahend, rsp_ready,
        output req_ready, rsp_valid, rsp_diff, rsp_borrow, rsp_id
    );
endinterface

// File: rtl/sub_share_arbiter.sv
// ---------------------------------------------------------------------------
// sub_share_arbiter -- one WIDTH-bit subtractor shared by NREQ requesters.
//
// A winner is picked among the pending requesters, its operand pair is
// latched, the difference is formed in a single CALC cycle and then held in
// a result register until the consumer takes it. A new grant can be issued
// in the same cycle the previous result is consumed, giving one result every
// two cycles under continuous rsp_ready.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - sub_share_if.slave (request lanes in, response out)
//
// Build option:
//   SUB_SHARE_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                            undefined -> round-robin starting at rr_ptr
// ---------------------------------------------------------------------------
module sub_share_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic      clk,
    input  logic      rst,
    sub_share_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state;

    // latched operand pair and owner of the in-flight operation
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [IDW-1:0]   op_id;

    // result register
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic [IDW-1:0]   id_q;
    logic             valid_q;

    logic             grant_en;
    logic             found;
    logic [IDW-1:0]   win;
    logic             take;
    logic [NREQ-1:0]  gnt_vec;
    logic [WIDTH:0]   sum;

`ifndef SUB_SHARE_FIXED_PRIO_EN
    logic [IDW-1:0]   rr_ptr;
`endif

    // Grants are only possible when the datapath is free: in IDLE, or in
    // RESP on the very cycle the held result is consumed. Reset masks the
    // grant so req_ready drops the moment rst rises.
    assign grant_en = !rst && ((state == S_IDLE) ||
                               ((state == S_RESP) && bus.rsp_ready));

    // -----------------------------------------------------------------------
    // Winner selection
    // -----------------------------------------------------------------------
`ifdef SUB_SHARE_FIXED_PRIO_EN
    // Scan downward so the last hit, i.e. the lowest index, wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if ((bus.req_valid & (NREQ'(1) << k)) != '0) begin
                found = 1'b1;
                win   = IDW'(k);
            end
        end
    end
`else
    // Walk upward from rr_ptr with wrap; first pending requester wins.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!found && ((bus.req_valid & (NREQ'(1) << idx)) != '0)) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end
`endif

    assign take = grant_en && found;

    always_comb begin
        gnt_vec = '0;
        if (take)
            gnt_vec = NREQ'(1) << win;
    end

    assign bus.req_ready = gnt_vec;

    // -----------------------------------------------------------------------
    // Subtraction as A + ~B + 1 at WIDTH+1 bits; the top bit is the carry,
    // and no carry means the minuend was smaller (borrow).
    // -----------------------------------------------------------------------
    assign sum = {1'b0, op_a} + {1'b0, ~op_b} + (WIDTH + 1)'(1);

    // -----------------------------------------------------------------------
    // Operand capture and pointer update on every accepted request
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a   <= '0;
            op_b   <= '0;
            op_id  <= '0;
`ifndef SUB_SHARE_FIXED_PRIO_EN
            rr_ptr <= '0;
`endif
        end else if (take) begin
            op_a   <= bus.req_minuend[int'(win) * WIDTH +: WIDTH];
            op_b   <= bus.req_subtrahend[int'(win) * WIDTH +: WIDTH];
            op_id  <= win;
`ifndef SUB_SHARE_FIXED_PRIO_EN
            rr_ptr <= IDW'((int'(win) + 1) % NREQ);
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM and result register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            id_q     <= '0;
            valid_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found)
                        state <= S_CALC;
                end
                S_CALC: begin
                    diff_q   <= sum[WIDTH-1:0];
                    borrow_q <= ~sum[WIDTH];
                    id_q     <= op_id;
                    valid_q  <= 1'b1;
                    state    <= S_RESP;
                end
                S_RESP: begin
                    // Result is held untouched until the consumer takes it.
                    if (bus.rsp_ready) begin
                        valid_q  <= 1'b0;
                        diff_q   <= '0;
                        borrow_q <= 1'b0;
                        state    <= found ? S_CALC : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.rsp_valid  = valid_q;
    assign bus.rsp_diff   = diff_q;
    assign bus.rsp_borrow = borrow_q;
    assign bus.rsp_id     = id_q;

endmodule

// File: tb/tb_sub_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sub_share_arbiter -- self-checking bench for sub_share_arbiter.
// Directed scenarios use constant expectations; the random scenario is
// checked against a transaction-level reference model (one outstanding
// result, grant allowed when free or on the consume cycle, result visible
// two cycles after its grant).
// ---------------------------------------------------------------------------
module tb_sub_share_arbiter;

    localparam int W = 8;
    localparam int N = 4;
    localparam int I = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sub_share_if #(.WIDTH(W), .NREQ(N), .IDW(I)) bus ();

    sub_share_arbiter #(.WIDTH(W), .NREQ(N), .IDW(I)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // requester operand storage
    logic [W-1:0] m_min [N];
    logic [W-1:0] m_sub [N];

    // reference model state
    bit           m_out;
    int           m_age;
    int           m_ptr;
    int           m_id;
    logic [W-1:0] m_diff;
    bit           m_borrow;
    bit           m_hs;
    bit           e_valid;
    int           e_win;
    logic [N-1:0] e_ready;

    function automatic int pick(logic [N-1:0] v, int ptr);
`ifdef SUB_SHARE_FIXED_PRIO_EN
        for (int i = 0; i < N; i++)
            if (((v >> i) & 1) != 0) return i;
`else
        for (int k = 0; k < N; k++)
            if (((v >> ((ptr + k) % N)) & 1) != 0) return (ptr + k) % N;
`endif
        return -1;
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < N; i++) begin
            bus.req_minuend[i*W +: W]    = m_min[i];
            bus.req_subtrahend[i*W +: W] = m_sub[i];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_out = 0; m_age = 0; m_ptr = 0; m_id = 0;
        m_diff = '0; m_borrow = 0; m_hs = 0;
    endtask

    task automatic model_eval();
        bit allow;
        e_valid = m_out && (m_age >= 2);
        m_hs    = e_valid && bus.rsp_ready;
        allow   = !m_out || m_hs;
        e_win   = pick(bus.req_valid, m_ptr);
        e_ready = '0;
        if (allow && e_win >= 0) e_ready = N'(1) << e_win;
    endtask

    task automatic model_commit();
        if (m_hs) m_out = 0;
        if (e_ready != '0) begin
            m_out    = 1;
            m_age    = 1;
            m_id     = e_win;
            m_diff   = m_min[e_win[I-1:0]] - m_sub[e_win[I-1:0]];
            m_borrow = m_min[e_win[I-1:0]] < m_sub[e_win[I-1:0]];
`ifndef SUB_SHARE_FIXED_PRIO_EN
            m_ptr    = (e_win + 1) % N;
`endif
        end else if (m_out) begin
            m_age++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin m_min[i] = '0; m_sub[i] = '0; end
        drive_ops();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic drain();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (4) tick();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = '1;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin m_min[i] = 8'h11; m_sub[i] = 8'h01; end
        drive_ops();
        @(negedge clk);
        checks++; if (bus.req_ready !== '0) begin failures++; $display("FAIL reset_req_ready: got %b expected 0", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
        checks++; if (bus.rsp_diff !== '0) begin failures++; $display("FAIL reset_rsp_diff: got %h expected 00", bus.rsp_diff); end
        checks++; if (bus.rsp_borrow !== 1'b0) begin failures++; $display("FAIL reset_rsp_borrow: got %b expected 0", bus.rsp_borrow); end
        checks++; if (bus.rsp_id !== '0) begin failures++; $display("FAIL reset_rsp_id: got %0d expected 0", bus.rsp_id); end
        tick();
        rst = 1'b0;
        bus.req_valid = 4'b0010;
        m_min[1] = 8'h09; m_sub[1] = 8'h04;
        drive_ops();
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL rst_pre_grant: got %b expected 0010", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        tick();
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL rst_pre_valid: got %b expected 1", bus.rsp_valid); end
        checks++; if (bus.rsp_diff !== 8'h05) begin failures++; $display("FAIL rst_pre_diff: got %h expected 05", bus.rsp_diff); end
        bus.req_valid = '1;
        #1 rst = 1'b1;
        #1;
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid: got %b expected 0", bus.rsp_valid); end
        checks++; if (bus.req_ready !== '0) begin failures++; $display("FAIL rst_async_ready: got %b expected 0", bus.req_ready); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL rst_restart_grant: got %b expected 0001", bus.req_ready); end
        tick();
        drain();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_single();
        do_reset();
        m_min[0] = 8'h05; m_sub[0] = 8'h03;
        drive_ops();
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL single_grant: got %b expected 0001", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL single_calc_valid: got %b expected 0", bus.rsp_valid); end
        tick();
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %b expected 1", bus.rsp_valid); end
        checks++; if (bus.rsp_diff !== 8'h02) begin failures++; $display("FAIL single_diff: got %h expected 02", bus.rsp_diff); end
        checks++; if (bus.rsp_borrow !== 1'b0) begin failures++; $display("FAIL single_borrow: got %b expected 0", bus.rsp_borrow); end
        checks++; if (bus.rsp_id !== 2'd0) begin failures++; $display("FAIL single_id: got %0d expected 0", bus.rsp_id); end
        tick();
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL single_consumed: got %b expected 0", bus.rsp_valid); end
        tick();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_borrow();
        logic [W-1:0] t_min [4];
        logic [W-1:0] t_sub [4];
        logic [W-1:0] t_dif [4];
        logic         t_bor [4];
        t_min[0] = 8'h03; t_sub[0] = 8'h05; t_dif[0] = 8'hFE; t_bor[0] = 1'b1;
        t_min[1] = 8'h00; t_sub[1] = 8'hFF; t_dif[1] = 8'h01; t_bor[1] = 1'b1;
        t_min[2] = 8'hA5; t_sub[2] = 8'hA5; t_dif[2] = 8'h00; t_bor[2] = 1'b0;
        t_min[3] = 8'h7C; t_sub[3] = 8'h00; t_dif[3] = 8'h7C; t_bor[3] = 1'b0;
        do_reset();
        bus.rsp_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            m_min[2] = t_min[t]; m_sub[2] = t_sub[t];
            drive_ops();
            bus.req_valid = 4'b0100;
            @(negedge clk);
            checks++; if (bus.req_ready !== 4'b0100) begin failures++; $display("FAIL borrow_grant[%0d]: got %b expected 0100", t, bus.req_ready); end
            tick();
            bus.req_valid = '0;
            tick();
            @(negedge clk);
            checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL borrow_valid[%0d]: got %b expected 1", t, bus.rsp_valid); end
            checks++; if (bus.rsp_diff !== t_dif[t]) begin failures++; $display("FAIL borrow_diff[%0d]: got %h expected %h", t, bus.rsp_diff, t_dif[t]); end
            checks++; if (bus.rsp_borrow !== t_bor[t]) begin failures++; $display("FAIL borrow_flag[%0d]: got %b expected %b", t, bus.rsp_borrow, t_bor[t]); end
            checks++; if (bus.rsp_id !== 2'd2) begin failures++; $display("FAIL borrow_id[%0d]: got %0d expected 2", t, bus.rsp_id); end
            tick();
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_round_robin();
        int           ord;
        int           prev;
        logic [N-1:0] exp;
        logic [W-1:0] d;
        do_reset();
        for (int i = 0; i < N; i++) begin m_min[i] = W'(8'h10 * (i + 1) + i); m_sub[i] = W'(i); end
        drive_ops();
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
`ifdef SUB_SHARE_FIXED_PRIO_EN
            ord = 0; prev = 0;
`else
            ord = (c / 2) % N; prev = ((c / 2) + N - 1) % N;
`endif
            exp = (c % 2 == 0) ? (N'(1) << ord) : '0;
            checks++; if (bus.req_ready !== exp) begin failures++; $display("FAIL rr_grant[c%0d]: got %b expected %b", c, bus.req_ready, exp); end
            if (c >= 2 && c % 2 == 0) begin
                d = m_min[prev[I-1:0]] - m_sub[prev[I-1:0]];
                checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== prev[I-1:0] || bus.rsp_diff !== d)
                    begin failures++; $display("FAIL rr_result[c%0d]: got v=%b id=%0d d=%h expected v=1 id=%0d d=%h", c, bus.rsp_valid, bus.rsp_id, bus.rsp_diff, prev, d); end
            end
            tick();
        end
        drain();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_two_req();
        logic [N-1:0] exp;
        do_reset();
        for (int i = 0; i < N; i++) begin m_min[i] = 8'h80; m_sub[i] = W'(i); end
        drive_ops();
        bus.req_valid = 4'b1001;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c == 7) bus.req_valid = 4'b1000;
            @(negedge clk);
            if (c % 2 != 0)         exp = '0;
            else if (c == 8)        exp = 4'b1000;
`ifdef SUB_SHARE_FIXED_PRIO_EN
            else                    exp = 4'b0001;
`else
            else                    exp = ((c / 2) % 2 == 0) ? 4'b0001 : 4'b1000;
`endif
            checks++; if (bus.req_ready !== exp) begin failures++; $display("FAIL two_req_grant[c%0d]: got %b expected %b", c, bus.req_ready, exp); end
            tick();
        end
        drain();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_backpressure();
        do_reset();
        m_min[0] = 8'h40; m_sub[0] = 8'h41;
        m_min[1] = 8'h22; m_sub[1] = 8'h11;
        drive_ops();
        bus.req_valid = 4'b0011;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL bp_first_grant: got %b expected 0001", bus.req_ready); end
        tick();
        bus.req_valid = 4'b0010;
        @(negedge clk);
        checks++; if (bus.req_ready !== '0) begin failures++; $display("FAIL bp_calc_grant: got %b expected 0", bus.req_ready); end
        tick();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (bus.req_ready !== '0) begin failures++; $display("FAIL bp_hold_grant[%0d]: got %b expected 0", c, bus.req_ready); end
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_diff !== 8'hFF || bus.rsp_borrow !== 1'b1 || bus.rsp_id !== 2'd0)
                begin failures++; $display("FAIL bp_hold_result[%0d]: got v=%b d=%h b=%b id=%0d expected v=1 d=ff b=1 id=0", c, bus.rsp_valid, bus.rsp_diff, bus.rsp_borrow, bus.rsp_id); end
            tick();
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL bp_release_grant: got %b expected 0010", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        tick();
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_diff !== 8'h11 || bus.rsp_id !== 2'd1)
            begin failures++; $display("FAIL bp_second_result: got v=%b d=%h id=%0d expected v=1 d=11 id=1", bus.rsp_valid, bus.rsp_diff, bus.rsp_id); end
        tick();
        drain();
    endtask

    // -----------------------------------------------------------------------
    task automatic new_ops(int i);
        int r;
        r = $urandom % 8;
        case (r)
            0: begin m_min[i[I-1:0]] = W'($urandom); m_sub[i[I-1:0]] = m_min[i[I-1:0]]; end
            1: begin m_min[i[I-1:0]] = W'($urandom); m_sub[i[I-1:0]] = '0; end
            2: begin m_min[i[I-1:0]] = '0;           m_sub[i[I-1:0]] = '1; end
            default: begin m_min[i[I-1:0]] = W'($urandom); m_sub[i[I-1:0]] = W'($urandom); end
        endcase
    endtask

    task automatic test_random();
        logic [N-1:0] v;
        logic [N-1:0] last;
        do_reset();
        v    = '0;
        last = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (last[i]) begin
                    v[i] = 1'($urandom % 2);
                    new_ops(i);
                end else if (!v[i]) begin
                    if ($urandom % 3 == 0) begin v[i] = 1'b1; new_ops(i); end
                end else if ($urandom % 16 == 0) begin
                    v[i] = 1'b0;
                end
            end
            bus.req_valid = v;
            bus.rsp_ready = ($urandom % 4) != 0;
            drive_ops();
            @(negedge clk);
            model_eval();
            checks++; if (bus.req_ready !== e_ready) begin failures++; $display("FAIL rand_grant[%0d]: got %b expected %b", cyc, bus.req_ready, e_ready); end
            checks++; if (bus.rsp_valid !== e_valid) begin failures++; $display("FAIL rand_valid[%0d]: got %b expected %b", cyc, bus.rsp_valid, e_valid); end
            if (e_valid) begin
                checks++; if (bus.rsp_diff !== m_diff || bus.rsp_borrow !== m_borrow || bus.rsp_id !== m_id[I-1:0])
                    begin failures++; $display("FAIL rand_result[%0d]: got d=%h b=%b id=%0d expected d=%h b=%b id=%0d", cyc, bus.rsp_diff, bus.rsp_borrow, bus.rsp_id, m_diff, m_borrow, m_id); end
            end
            model_commit();
            last = e_ready;
            tick();
        end
        drain();
    endtask

    initial begin
        bus.req_valid      = '0;
        bus.req_minuend    = '0;
        bus.req_subtrahend = '0;
        bus.rsp_ready      = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_borrow();
        test_round_robin();
        test_two_req();
        test_backpressure();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sub_share_arbiter.md
Name: sub_share_arbiter

Overview:
- Shares one WIDTH-bit subtractor datapath among NREQ requesters.
- Round-robin arbitration; operands latched, difference computed and held in a result register until consumed.
- Valid/ready handshakes on both sides; sits between client blocks and the arithmetic datapath.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2)
- NREQ, 4, number of requesters (>=2)
- IDW, 2, requester-id width; must satisfy 2**IDW >= NREQ

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  NREQ  bit i: requester i has an operand pair pending
- req_minuend  input  NREQ*WIDTH  slice i = bits [i*WIDTH +: WIDTH]
- req_subtrahend  input  NREQ*WIDTH  slice i as above
- req_ready  output  NREQ  one-hot grant; bit i high for exactly the accept cycle of requester i
- rsp_valid  output  1  result register holds a valid result
- rsp_ready  input  1  consumer accepts result
- rsp_diff  output  WIDTH  minuend - subtrahend mod 2**WIDTH
- rsp_borrow  output  1  1 when minuend < subtrahend (unsigned)
- rsp_id  output  IDW  index of the requester that owns the result

Behaviour:
- Reset, asynchronous, any state: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_diff=0, rsp_borrow=0, rsp_id=0, operand regs=0.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - If any req_valid: grant the winner (req_ready[w]=1, combinational from req_valid and rr_ptr).
  - Latch the winner's operands and id; go to CALC. Otherwise stay.
- CALC (exactly 1 cycle):
  - diff = opA + ~opB + 1, computed at WIDTH+1 bits.
  - rsp_diff = low WIDTH bits; rsp_borrow = inverted carry-out.
  - Register results, set rsp_valid=1, go to RESP.
  - No grants in CALC.
- RESP:
  - rsp_valid=1; rsp_diff, rsp_borrow and rsp_id stay stable until the handshake.
  - On rsp_valid & rsp_ready with any req_valid: clear old result, grant the new winner in the same cycle, latch its operands, go to CALC.
  - On rsp_valid & rsp_ready with no req_valid: rsp_valid=0, go to IDLE.
  - Without rsp_ready: stay, no grants.
- Latency: grant at cycle N, rsp_valid rises at N+2.
- Throughput: 1 result per 2 cycles under continuous rsp_ready.
- Arbitration: search from rr_ptr upward with wrap at NREQ-1 -> 0; first set req_valid wins. After a grant to w, rr_ptr = (w+1) mod NREQ. No grant -> rr_ptr unchanged.
- req_valid deasserted before grant: the request is simply not considered; no state change.
- Requesters must hold their operands stable while req_valid is high.
- req_ready is never asserted for a requester whose req_valid is low; at most one req_ready bit is high per cycle.
- Boundaries:
  - minuend == subtrahend -> diff=0, borrow=0.
  - subtrahend=0 -> diff=minuend, borrow=0.
  - minuend=0, subtrahend=all-ones -> diff=1, borrow=1.
- Reset during CALC or RESP discards the in-flight result; no rsp handshake occurs for it.

Optional Feature:
- Macro SUB_SHARE_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr_ptr is neither implemented nor updated.
- Undefined (default): round-robin as in Behaviour.
- All other timing is identical in both builds.

Test Plan:
- Reset: assert rst while in RESP with rsp_valid=1 -> rsp_valid=0, req_ready=0 immediately; next grant starts search at requester 0.
- Single request: req 0 min=0x05 sub=0x03, rsp_ready=1 -> req_ready[0] at N; at N+2 rsp_valid=1, diff=0x02, borrow=0, id=0.
- Borrow case: req 2 min=0x03 sub=0x05 -> diff=0xFE, borrow=1, id=2. Also min=0x00 sub=0xFF -> diff=0x01, borrow=1.
- Round-robin: all four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0,1; grants every 2 cycles.
- Backpressure: rsp_ready=0 for 5 cycles with requests pending -> rsp_diff, rsp_borrow and rsp_id stable; no req_ready bits; at the rsp_ready cycle the next grant occurs in that same cycle.
- With SUB_SHARE_FIXED_PRIO_EN: req 0 and req 3 held high -> every grant goes to 0; drop req 0 -> 3 is granted.
